// File: rtl/iir_lpf_mc_if.sv
// Sample/result handshake bundle for the multi-channel IIR low-pass filter.
// The master side is the producer/consumer; the slave side is the filter.
interface iir_lpf_mc_if #(
    parameter int DATA_W = 16,
    parameter int CH_W   = 2
);
    logic signed [DATA_W-1:0] x_data;
    logic        [CH_W-1:0]   x_ch;
    logic                     x_data_valid;
    logic                     x_data_ready;
    logic                     bypass;
    logic signed [DATA_W-1:0] y_data;
    logic        [CH_W-1:0]   y_ch;
    logic                     y_data_valid;
    logic                     y_ack;
    logic                     ch_err;

    modport master (
        output x_data, x_ch, x_data_valid, bypass, y_ack,
        input  x_data_ready, y_data, y_ch, y_data_valid, ch_err
    );

    modport slave (
        input  x_data, x_ch, x_data_valid, bypass, y_ack,
        output x_data_ready, y_data, y_ch, y_data_valid, ch_err
    );
endinterface

// File: rtl/iir_lpf_mc.sv
// Time-multiplexed multi-channel first-order IIR low-pass filter:
// y[n] = y[n-1] + ((x[n] - y[n-1]) >>> SHIFT), one state register per channel.
module iir_lpf_mc #(
    parameter int DATA_W = 16,
    parameter int N_CH   = 4,
    parameter int CH_W   = 2,
    parameter int SHIFT  = 2,
    parameter int PRIME  = 1
) (
    input  logic          i_CLK,
    input  logic          i_RST,
    iir_lpf_mc_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_UPD  = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    localparam logic [CH_W:0] N_CH_L = (CH_W + 1)'(N_CH);

    state_t                   state_r;
    state_t                   next_s;
    logic signed [DATA_W-1:0] x_r;
    logic        [CH_W-1:0]   ch_r;
    logic                     byp_r;
    logic signed [DATA_W:0]   diff_r;
    logic signed [DATA_W-1:0] ch_state_r [N_CH];
    logic        [N_CH-1:0]   primed_r;
    logic signed [DATA_W-1:0] y_data_r;
    logic        [CH_W-1:0]   y_ch_r;
    logic                     y_valid_r;
    logic                     ready_r;
    logic                     ch_err_r;

    logic                     ch_ok_s;
    logic                     accept_s;
    logic                     bad_s;
    logic                     ack_s;
    logic signed [DATA_W-1:0] cur_s;
    logic signed [DATA_W:0]   cur_ext_s;
    logic signed [DATA_W:0]   x_ext_s;
    logic signed [DATA_W:0]   sum_s;
    logic                     prime_s;
    logic signed [DATA_W-1:0] y_s;

    assign ch_ok_s = ({1'b0, bus.x_ch} < N_CH_L);

    // State register of the sequencing FSM.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state and handshake decisions.
    always_comb begin
        next_s   = state_r;
        accept_s = 1'b0;
        bad_s    = 1'b0;
        ack_s    = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (bus.x_data_valid) begin
                    if (ch_ok_s) begin
                        accept_s = 1'b1;
                        next_s   = S_CALC;
                    end else begin
                        bad_s  = 1'b1;
                        next_s = S_IDLE;
                    end
                end else begin
                    next_s = S_IDLE;
                end
            end
            S_CALC: next_s = S_UPD;
            S_UPD:  next_s = S_OUT;
            S_OUT: begin
                if (bus.y_ack) begin
                    ack_s  = 1'b1;
                    next_s = S_IDLE;
                end else begin
                    next_s = S_OUT;
                end
            end
            default: next_s = S_IDLE;
        endcase
    end

    // Filter arithmetic; the unprimed/bypass cases pass x straight through.
    always_comb begin
        cur_s     = ch_state_r[ch_r];
        cur_ext_s = {cur_s[DATA_W-1], cur_s};
        x_ext_s   = {x_r[DATA_W-1], x_r};
        sum_s     = cur_ext_s + (diff_r >>> SHIFT);
        prime_s   = (PRIME != 32'sd0) && !primed_r[ch_r];
        if (byp_r || prime_s) begin
            y_s = x_r;
        end else begin
            y_s = sum_s[DATA_W-1:0];
        end
    end

    // Sample capture, channel state update and registered outputs.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            x_r       <= '0;
            ch_r      <= '0;
            byp_r     <= 1'b0;
            diff_r    <= '0;
            primed_r  <= '0;
            y_data_r  <= '0;
            y_ch_r    <= '0;
            y_valid_r <= 1'b0;
            ready_r   <= 1'b1;
            ch_err_r  <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                ch_state_r[i] <= '0;
            end
        end else begin
            ch_err_r <= bad_s;
            ready_r  <= (next_s == S_IDLE);
            if (accept_s) begin
                x_r   <= bus.x_data;
                ch_r  <= bus.x_ch;
                byp_r <= bus.bypass;
            end
            if (state_r == S_CALC) begin
                diff_r <= x_ext_s - cur_ext_s;
            end
            // y sits between old state and x, so truncation never wraps.
            if (state_r == S_UPD) begin
                ch_state_r[ch_r] <= y_s;
                primed_r[ch_r]   <= 1'b1;
                y_data_r         <= y_s;
                y_ch_r           <= ch_r;
                y_valid_r        <= 1'b1;
            end else if (ack_s) begin
                y_valid_r <= 1'b0;
            end
        end
    end

    assign bus.x_data_ready = ready_r;
    assign bus.y_data       = y_data_r;
    assign bus.y_ch         = y_ch_r;
    assign bus.y_data_valid = y_valid_r;
    assign bus.ch_err       = ch_err_r;
endmodule
